ps2_key_decoder: RTL
====================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical ps2c samples required to change the filtered clock level.
REQ-002 Parameter TIMEOUT_CYC, default 100000: clk cycles without a filtered ps2c falling edge, mid-frame, before the frame is aborted.
REQ-003 clk  input  1  system clock; the only clock in the block.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 ps2d  input  1  PS/2 data line, asynchronous to clk.
REQ-006 ps2c  input  1  PS/2 clock line, asynchronous to clk.
REQ-007 left_key  output  1  level, high while left arrow (E0 6B) is held.
REQ-008 right_key  output  1  level, high while right arrow (E0 74) is held.
REQ-009 enter_key  output  1  one-cycle pulse on an Enter (5A) make, but only when Enter was not already held.
REQ-010 key_release  output  1  one-cycle pulse on a break of any of the three decoded keys.
REQ-011 scan_code  output  8  last accepted data byte, prefixes included.
REQ-012 code_valid  output  1  one-cycle pulse when scan_code updates.
REQ-013 frame_err  output  1  one-cycle pulse when a frame is discarded.

Function
REQ-014 ps2c and ps2d shall pass through a 2-FF synchronizer; ps2c shall then pass through a FILTER_LEN-sample glitch filter.
REQ-015 A falling edge of the filtered ps2c shall sample the synchronized ps2d exactly once.
REQ-016 The frame FSM shall have states IDLE, RX, and DONE; IDLE->RX on a sampled 0 (start bit); a sampled 1 in IDLE shall be ignored.
REQ-017 RX shall shift 10 further bits, LSB first: 8 data bits, parity, stop; it shall then enter DONE.
REQ-018 DONE shall last 1 cycle, accept the frame if stop=1 (and parity is valid, per REQ-030), and return to IDLE.
REQ-019 An accepted frame shall update scan_code and pulse code_valid 1 cycle after the DONE cycle; a rejected frame shall pulse frame_err instead.
REQ-020 In RX, a cycle counter reaching TIMEOUT_CYC shall abort the frame (pulse frame_err, go to IDLE); the counter shall clear on each sampled edge.
REQ-021 Decode flags ext and brk: byte E0 sets ext; byte F0 sets brk; any other byte is decoded using the flags, after which both flags clear.
REQ-022 Make of E0 6B or E0 74 shall set left_key or right_key respectively; the matching break shall clear it and pulse key_release.
REQ-023 Make of 5A without ext shall pulse enter_key only if the internal enter_held flag is 0, then set enter_held; a break of 5A shall clear enter_held and pulse key_release.
REQ-024 Typematic repeats of a held key shall produce no additional enter_key or key_release pulses and shall leave levels unchanged.
REQ-025 A 6B or 74 byte without ext (keypad) shall not affect left_key or right_key.
REQ-026 A rejected or aborted frame shall clear ext and brk.
REQ-027 left_key and right_key may both be high simultaneously; no priority shall be applied.

Reset
REQ-028 Asserting reset (low) shall immediately force: FSMs to IDLE, counters and shift register to 0, ext, brk, and enter_held to 0, and all outputs to 0.
REQ-029 A reset asserted mid-frame shall discard the partial frame; after release, the next start bit shall begin a fresh frame.

Configuration
REQ-030 With macro PS2_PARITY_CHECK_EN defined, DONE shall also require odd parity over data+parity, otherwise reject with frame_err; without the macro, parity shall be ignored and only the stop bit checked.

Verification
REQ-031 Send frame 5A (parity 1, stop 1) -> scan_code=8'h5A, one code_valid pulse, one enter_key pulse; send 5A again -> no enter_key pulse.
REQ-032 Send E0,6B, then E0,F0,6B -> left_key rises after the second byte and falls after the fifth byte, with exactly one key_release pulse.
REQ-033 Send 5A with parity 0 -> with PS2_PARITY_CHECK_EN: frame_err pulse, scan_code unchanged; without it: scan_code=8'h5A.
REQ-034 Send the start bit plus 4 bits, then idle TIMEOUT_CYC+10 cycles -> one frame_err pulse, FSM in IDLE; a following frame 74 is accepted.
REQ-035 Inject 3-cycle ps2c glitches (with FILTER_LEN=8) during IDLE -> no sampling and no outputs; assert reset mid-frame -> all outputs 0, next full frame decoded correctly.

Source files
------------

// File: rtl/ps2_key_decoder_if.sv
// Signal bundle between a PS/2 line driver and the ps2_key_decoder.
// The decoder uses the slave modport; the driver/observer side uses master.
interface ps2_key_decoder_if;
  logic       ps2c;
  logic       ps2d;
  logic       left_key;
  logic       right_key;
  logic       enter_key;
  logic       key_release;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       frame_err;

  modport master (
    output ps2c, ps2d,
    input  left_key, right_key, enter_key, key_release, scan_code, code_valid, frame_err
  );

  modport slave (
    input  ps2c, ps2d,
    output left_key, right_key, enter_key, key_release, scan_code, code_valid, frame_err
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizer, ps2c glitch filter, frame FSM and arrow/Enter decoder.
// Define PS2_PARITY_CHECK_EN to also reject frames whose odd parity is wrong.
module ps2_key_decoder #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic               clk,
  input  logic               reset,
  ps2_key_decoder_if.slave   bus
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] B_EXT   = 8'hE0;
  localparam logic [7:0] B_BRK   = 8'hF0;
  localparam logic [7:0] B_LEFT  = 8'h6B;
  localparam logic [7:0] B_RIGHT = 8'h74;
  localparam logic [7:0] B_ENTER = 8'h5A;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PARITY_CHECK = 1'b1;
`else
  localparam bit PARITY_CHECK = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, RX, DONE} state_t;

  logic          ps2c_s1, ps2c_s2, ps2d_s1, ps2d_s2;
  logic          ps2c_filt;
  logic [FW-1:0] flt_cnt;
  logic          bit_stb, bit_val;

  // The filtered level only flips after FILTER_LEN consecutive differing samples;
  // bit_stb marks the 1->0 flip and bit_val holds ps2d from that same cycle.
  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ps2c_s1   <= 1'b0;
      ps2c_s2   <= 1'b0;
      ps2d_s1   <= 1'b0;
      ps2d_s2   <= 1'b0;
      ps2c_filt <= 1'b0;
      flt_cnt   <= '0;
      bit_stb   <= 1'b0;
      bit_val   <= 1'b0;
    end else begin
      ps2c_s1 <= bus.ps2c;
      ps2c_s2 <= ps2c_s1;
      ps2d_s1 <= bus.ps2d;
      ps2d_s2 <= ps2d_s1;
      bit_val <= ps2d_s2;
      bit_stb <= 1'b0;
      if (ps2c_s2 != ps2c_filt) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          ps2c_filt <= ps2c_s2;
          flt_cnt   <= '0;
          bit_stb   <= ps2c_filt;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  state_t        state, state_nx;
  logic [9:0]    shreg;
  logic [3:0]    bit_cnt;
  logic [TW-1:0] to_cnt;
  logic          accept, reject, abort;
  logic          parity_ok;
  logic [7:0]    rx_byte;

  assign rx_byte   = shreg[7:0];
  assign parity_ok = !PARITY_CHECK || (^shreg[8:0]);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    reject   = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: if (bit_stb && !bit_val) state_nx = RX;
      RX: begin
        if (bit_stb) begin
          if (bit_cnt == 4'd9) state_nx = DONE;
        end else if (to_cnt == TW'(TIMEOUT_CYC - 1)) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end
      end
      DONE: begin
        state_nx = IDLE;
        if (shreg[9] && parity_ok) accept = 1'b1;
        else                       reject = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Shift register is reset too so a frame cut short by reset leaves nothing behind.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      to_cnt  <= '0;
    end else begin
      state <= state_nx;
      if (state == RX) begin
        if (bit_stb) begin
          shreg   <= {bit_val, shreg[9:1]};
          bit_cnt <= bit_cnt + 1'b1;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end else begin
        bit_cnt <= '0;
        to_cnt  <= '0;
      end
    end
  end

  logic ext, brk, enter_held;

  // Byte decoder: outputs land one cycle after DONE, alongside code_valid / frame_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext             <= 1'b0;
      brk             <= 1'b0;
      enter_held      <= 1'b0;
      bus.left_key    <= 1'b0;
      bus.right_key   <= 1'b0;
      bus.enter_key   <= 1'b0;
      bus.key_release <= 1'b0;
      bus.scan_code   <= '0;
      bus.code_valid  <= 1'b0;
      bus.frame_err   <= 1'b0;
    end else begin
      bus.enter_key   <= 1'b0;
      bus.key_release <= 1'b0;
      bus.code_valid  <= accept;
      bus.frame_err   <= reject || abort;
      if (reject || abort) begin
        ext <= 1'b0;
        brk <= 1'b0;
      end else if (accept) begin
        bus.scan_code <= rx_byte;
        if (rx_byte == B_EXT) begin
          ext <= 1'b1;
        end else if (rx_byte == B_BRK) begin
          brk <= 1'b1;
        end else begin
          ext <= 1'b0;
          brk <= 1'b0;
          if (ext && rx_byte == B_LEFT) begin
            bus.left_key    <= !brk;
            bus.key_release <= brk;
          end else if (ext && rx_byte == B_RIGHT) begin
            bus.right_key   <= !brk;
            bus.key_release <= brk;
          end else if (!ext && rx_byte == B_ENTER) begin
            if (brk) begin
              enter_held      <= 1'b0;
              bus.key_release <= 1'b1;
            end else if (!enter_held) begin
              enter_held    <= 1'b1;
              bus.enter_key <= 1'b1;
            end
          end
        end
      end
    end
  end

endmodule
